// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multicycle control unit and its ALU decoder.
package ctrl_pkg;

    localparam int unsigned OPW = 6;
    localparam int unsigned FNW = 6;
    localparam int unsigned ACW = 3;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    localparam logic [FNW-1:0] FN_ADD = 6'b100000;
    localparam logic [FNW-1:0] FN_SUB = 6'b100010;
    localparam logic [FNW-1:0] FN_AND = 6'b100100;
    localparam logic [FNW-1:0] FN_OR  = 6'b100101;

    // bit2 inverts B with carry-in, bit0 picks adder, bit1 picks AND over OR
    localparam logic [ACW-1:0] ALU_ADD = 3'b001;
    localparam logic [ACW-1:0] ALU_SUB = 3'b101;
    localparam logic [ACW-1:0] ALU_AND = 3'b010;
    localparam logic [ACW-1:0] ALU_OR  = 3'b000;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_e;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_REXEC,
        ST_RWB,
        ST_BEQEX,
        ST_ADDIEX,
        ST_ADDIWB,
        ST_JEX,
        ST_ILLEGAL
    } state_e;

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class (and funct for R-type) onto the 3-bit ALU control word.
module alu_decoder
    import ctrl_pkg::*;
(
    input  aluop_e         aluop_i,
    input  logic [FNW-1:0] funct_i,
    output logic [ACW-1:0] alu_ctrl_o,
    output logic           bad_funct_o
);

    always_comb begin
        alu_ctrl_o  = ALU_ADD;
        bad_funct_o = 1'b0;
        case (aluop_i)
            ALUOP_ADD: alu_ctrl_o = ALU_ADD;
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    default: bad_funct_o = 1'b1;
                endcase
            end
            default: bad_funct_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing each instruction FETCH..WRITEBACK and driving datapath controls.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [FNW-1:0] funct,
    input  logic           zero,
    output logic           ir_write,
    output logic           iord,
    output logic           mem_write,
    output logic           reg_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [ACW-1:0] alu_ctrl,
    output logic [1:0]     pc_src,
    output logic           pc_en,
    output logic           illegal
);

    state_e         state_q, state_d;
    logic           illegal_q;
    aluop_e         aluop;
    logic [ACW-1:0] dec_alu_ctrl;
    logic           bad_funct;
    logic           ir_write_s, iord_s, mem_write_s, reg_write_s, reg_dst_s;
    logic           mem_to_reg_s, alu_src_a_s, pc_write_s, branch_s;
    logic [1:0]     alu_src_b_s, pc_src_s;

    alu_decoder u_alu_dec (
        .aluop_i     (aluop),
        .funct_i     (funct),
        .alu_ctrl_o  (dec_alu_ctrl),
        .bad_funct_o (bad_funct)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == ST_ILLEGAL);
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_write_s   = 1'b0;
        iord_s       = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        pc_src_s     = 2'b00;
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        aluop        = ALUOP_ADD;
        case (state_q)
            ST_FETCH: begin
                ir_write_s  = 1'b1;
                alu_src_b_s = 2'b01;
                pc_write_s  = 1'b1;
                state_d     = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_b_s = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = ST_REXEC;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BEQEX;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JEX;
                    default:      state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                state_d     = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                iord_s  = 1'b1;
                state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_MEMWR: begin
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_REXEC: begin
                alu_src_a_s = 1'b1;
                aluop       = ALUOP_FUNCT;
                state_d     = bad_funct ? ST_ILLEGAL : ST_RWB;
            end
            ST_RWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_BEQEX: begin
                alu_src_a_s = 1'b1;
                aluop       = ALUOP_SUB;
                pc_src_s    = 2'b01;
                branch_s    = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                state_d     = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                reg_write_s = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_JEX: begin
                pc_src_s   = 2'b10;
                pc_write_s = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_ILLEGAL: state_d = ST_ILLEGAL;
            default:    state_d = ST_ILLEGAL;
        endcase
    end

    // reset masks every enable/select immediately, independent of the state register
    always_comb begin
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        alu_ctrl   = ALU_ADD;
        if (!reset) begin
            ir_write   = ir_write_s;
            iord       = iord_s;
            mem_write  = mem_write_s;
            reg_write  = reg_write_s;
            reg_dst    = reg_dst_s;
            mem_to_reg = mem_to_reg_s;
            alu_src_a  = alu_src_a_s;
            alu_src_b  = alu_src_b_s;
            pc_src     = pc_src_s;
            pc_en      = pc_write_s | (branch_s & zero);
            alu_ctrl   = dec_alu_ctrl;
        end
    end

    assign illegal = illegal_q;

endmodule
